i2f_share_ctrl: RTL and testbench

Round-robin controller that shares one combinational int_to_float converter (8-bit unsigned integer to IEEE-754 single) among NUM_REQ requesters. It accepts one operand at a time over a valid/ready handshake and registers the operand and the result. It returns the float with the requester ID over a valid/ready response channel. It sits between integer producers and the float datapath, so the converter is instantiated once instead of per client.

---
 rtl/i2f_pkg.sv | 16 +
 rtl/i2f_rr_arbiter.sv | 29 ++
 rtl/int_to_float.sv | 30 +++
 rtl/i2f_share_ctrl.sv | 114 +++++++++++
 tb/tb_i2f_share_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2f_pkg.sv
// Shared types and constants for the shared int-to-float controller.
package i2f_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int INT_W    = 8;
  localparam int FLOAT_W  = 32;
  localparam int EXP_BIAS = 127;

  localparam logic [FLOAT_W-1:0] FLOAT_ZERO = 32'h0000_0000;

endpackage

// File: rtl/i2f_rr_arbiter.sv
// Round-robin arbiter: searches upward from the requester after rr_ptr.
module i2f_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  // First set request strictly after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/int_to_float.sv
// Combinational 8-bit unsigned integer to IEEE-754 single converter.
// Every 8-bit value fits in the 24-bit significand, so the result is exact.
module int_to_float
  import i2f_pkg::*;
(
  input  logic [INT_W-1:0]   int_in,
  output logic [FLOAT_W-1:0] float_out
);

  logic [2:0]  msb_pos;
  logic [30:0] aligned;
  logic [7:0]  exp_field;

  // Locate the leading one, then shift it to the hidden-bit position (bit 23).
  always_comb begin
    msb_pos   = 3'd0;
    aligned   = '0;
    exp_field = '0;
    float_out = FLOAT_ZERO;
    for (int i = 0; i < INT_W; i++) begin
      if (int_in[i]) msb_pos = 3'(i);
    end
    if (int_in != '0) begin
      aligned   = {23'b0, int_in} << (5'd23 - {2'b00, msb_pos});
      exp_field = 8'(EXP_BIAS) + {5'b0, msb_pos};
      float_out = {1'b0, exp_field, aligned[22:0]};
    end
  end

endmodule

// File: rtl/i2f_share_ctrl.sv
// Shares one int_to_float converter among NUM_REQ requesters with
// round-robin arbitration and a registered valid/ready response channel.
module i2f_share_ctrl
  import i2f_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*INT_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [FLOAT_W-1:0]       resp_float,
  output logic [ID_W-1:0]          resp_id,
  output logic                     busy,
  output logic [CNT_W-1:0]         conv_count
);

  state_t             state_reg, state_next;
  logic [INT_W-1:0]   op_reg;
  logic [ID_W-1:0]    id_reg;
  logic [ID_W-1:0]    rr_ptr_reg;
  logic [FLOAT_W-1:0] resp_float_reg;
  logic [ID_W-1:0]    resp_id_reg;
  logic               resp_valid_reg;
  logic [CNT_W-1:0]   conv_count_reg;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_valid;
  logic [FLOAT_W-1:0] float_out;

  i2f_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req         (req_valid),
    .rr_ptr      (rr_ptr_reg),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // The converter only ever sees the registered operand.
  int_to_float u_conv (
    .int_in    (op_reg),
    .float_out (float_out)
  );

  // Next state and the combinational accept strobe (only in IDLE, out of reset).
  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    case (state_reg)
      IDLE: begin
        if (grant_valid && !rst) begin
          req_ready  = grant;
          state_next = CONV;
        end
      end
      CONV:    state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, operand capture, result registers and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      op_reg         <= '0;
      id_reg         <= '0;
      rr_ptr_reg     <= ID_W'(NUM_REQ - 1);
      resp_float_reg <= FLOAT_ZERO;
      resp_id_reg    <= '0;
      resp_valid_reg <= 1'b0;
      conv_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            op_reg     <= req_data[int'(grant_idx)*INT_W +: INT_W];
            id_reg     <= grant_idx;
            rr_ptr_reg <= grant_idx;
          end
        end
        CONV: begin
          resp_float_reg <= float_out;
          resp_id_reg    <= id_reg;
          resp_valid_reg <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_reg <= 1'b0;
            conv_count_reg <= conv_count_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = resp_valid_reg;
  assign resp_float = resp_float_reg;
  assign resp_id    = resp_id_reg;
  assign conv_count = conv_count_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_i2f_share_ctrl.sv
// Directed, table-driven bench for i2f_share_ctrl.
module tb_i2f_share_ctrl;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [31:0]          resp_float;
  logic [ID_W-1:0]      resp_id;
  logic                 busy;
  logic [CNT_W-1:0]     conv_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  data;
    int          exp_id;
    logic [31:0] exp_float;
  } vec_t;

  vec_t tbl [4];

  i2f_share_ctrl #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_float (resp_float),
    .resp_id    (resp_id),
    .busy       (busy),
    .conv_count (conv_count)
  );

  always #5 clk = ~clk;

  // Reference conversion written independently of the RTL structure.
  function automatic logic [31:0] ref_float(input int x);
    int e;
    int m;
    if (x == 0) return 32'h0;
    e = 0;
    while ((x >> (e + 1)) != 0) e++;
    m = (x - (1 << e)) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: inputs are driven and outputs sampled around the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Single isolated transaction from requester k; resp_ready raised once valid.
  task automatic do_txn(input int k, input logic [7:0] d, input logic [31:0] exp_f,
                        input logic [CNT_W-1:0] exp_cnt);
    req_valid         = '0;
    req_valid[k]      = 1'b1;
    req_data[k*8 +: 8] = d;
    resp_ready        = 1'b0;
    #1;
    check("txn_req_ready", 32'(req_ready), 32'(1 << k));
    step();
    req_valid = '0;
    #1;
    check("txn_busy_conv", 32'(busy), 32'd1);
    check("txn_no_early_valid", 32'(resp_valid), 32'd0);
    step();
    check("txn_resp_valid", 32'(resp_valid), 32'd1);
    check("txn_resp_float", resp_float, exp_f);
    check("txn_resp_id", 32'(resp_id), 32'(k));
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    #1;
    check("txn_valid_cleared", 32'(resp_valid), 32'd0);
    check("txn_conv_count", 32'(conv_count), 32'(exp_cnt));
    $display("txn req=%0d data=%0d float=%h id=%0d count=%0d", k, d, resp_float, resp_id, conv_count);
  endtask

  initial begin
    logic [31:0] held_f;
    logic [ID_W-1:0] held_id;

    tbl[0] = '{8'd3,   0, 32'h4040_0000};
    tbl[1] = '{8'd128, 1, 32'h4300_0000};
    tbl[2] = '{8'd255, 2, 32'h437F_0000};
    tbl[3] = '{8'd0,   3, 32'h0000_0000};

    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    resp_ready = 1'b0;
    @(negedge clk);

    // Reset state; req_ready must stay low while rst is high even with requests.
    req_valid = 4'b1111;
    step();
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_float", resp_float, 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_conv_count", 32'(conv_count), 32'd0);
    req_valid = '0;
    rst = 1'b0;
    step();
    check("idle_no_req", 32'(req_ready), 32'd0);

    // Single request from requester 0.
    do_txn(0, 8'd1, 32'h3F80_0000, 16'd1);

    // All four requesting, resp_ready tied high: round-robin 0,1,2,3.
    do_reset();
    resp_ready = 1'b1;
    req_valid  = 4'b1111;
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = tbl[i].data;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_grant", 32'(req_ready), 32'(1 << tbl[i].exp_id));
      step();
      req_valid[tbl[i].exp_id] = 1'b0;
      #1;
      check("rr_ready_conv", 32'(req_ready), 32'd0);
      step();
      check("rr_resp_valid", 32'(resp_valid), 32'd1);
      check("rr_resp_float", resp_float, tbl[i].exp_float);
      check("rr_resp_id", 32'(resp_id), 32'(tbl[i].exp_id));
      $display("txn rr id=%0d float=%h", resp_id, resp_float);
      step();
    end
    check("rr_count", 32'(conv_count), 32'd4);

    // Backpressure: requester 2 (pointer at 3 searches 0,1,2).
    resp_ready = 1'b0;
    req_valid  = 4'b0100;
    req_data[2*8 +: 8] = 8'd128;
    #1;
    check("bp_grant", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'b1111;
    step();
    held_f  = resp_float;
    held_id = resp_id;
    check("bp_first_float", held_f, 32'h4300_0000);
    check("bp_first_id", 32'(held_id), 32'd2);
    for (int c = 0; c < 10; c++) begin
      #1;
      check("bp_valid_hold", 32'(resp_valid), 32'd1);
      check("bp_float_hold", resp_float, 32'h4300_0000);
      check("bp_id_hold", 32'(resp_id), 32'd2);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_count_hold", 32'(conv_count), 32'd4);
      step();
    end
    resp_ready = 1'b1;
    req_valid  = '0;
    step();
    check("bp_release_valid", 32'(resp_valid), 32'd0);
    check("bp_release_count", 32'(conv_count), 32'd5);
    $display("txn bp id=%0d float=%h count=%0d", held_id, held_f, conv_count);

    // Fairness: pointer at 2, requesters 1 and 2 both held -> 1,2,1,2.
    req_data[1*8 +: 8] = 8'd10;
    req_data[2*8 +: 8] = 8'd20;
    req_valid = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      int exp_g;
      exp_g = (i % 2 == 0) ? 1 : 2;
      #1;
      check("fair_grant", 32'(req_ready), 32'(1 << exp_g));
      step();
      step();
      check("fair_resp_id", 32'(resp_id), 32'(exp_g));
      check("fair_resp_float", resp_float, ref_float(exp_g == 1 ? 10 : 20));
      $display("txn fair id=%0d float=%h", resp_id, resp_float);
      step();
    end
    req_valid = '0;
    check("fair_count", 32'(conv_count), 32'd9);

    // Reset while in CONV discards the operation.
    resp_ready = 1'b1;
    req_valid  = 4'b0001;
    req_data[7:0] = 8'd7;
    #1;
    check("mid_grant", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("mid_valid", 32'(resp_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_count", 32'(conv_count), 32'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("mid_no_resp", 32'(resp_valid), 32'd0);
    end
    $display("txn rst-discard count=%0d", conv_count);

    // Exhaustive sweep through requester 3.
    for (int v = 0; v < 256; v++) begin
      do_txn(3, 8'(v), ref_float(v), 16'(v + 1));
    end
    check("sweep_count", 32'(conv_count), 32'd256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
